// File: rtl/snake_trail.sv
// snake_trail: ring buffer of recent snake head positions with serial pixel
// hit-test queries and sticky self-collision detection.
module snake_trail #(
  parameter int DEPTH    = 16,
  parameter int BOX      = 5,
  parameter int INIT_LEN = 3
) (
  input  logic                       slow_clk,
  input  logic                       reset,
  input  logic [8:0]                 xpos,
  input  logic [8:0]                 ypos,
  input  logic                       grow,
  input  logic                       query_valid,
  input  logic [6:0]                 query_x,
  input  logic [5:0]                 query_y,
  output logic                       query_ready,
  output logic                       query_done,
  output logic                       query_hit,
  output logic                       query_head,
  output logic [$clog2(DEPTH):0]     length,
  output logic                       self_collision
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QSCAN = 2'd1;
  localparam logic [1:0] S_CSCAN = 2'd2;

  // Entry layout: {x[6:0], y[5:0]}
  logic [12:0]   ring_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [12:0]   last_head_q, last_head_d;
  logic [12:0]   adv_pos_q, adv_pos_d;
  logic          adv_pend_q, adv_pend_d;
  logic [LW-1:0] grow_pend_q, grow_pend_d;
  logic [LW-1:0] length_q, length_d;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [6:0]    qx_q, qx_d;
  logic [5:0]    qy_q, qy_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic          head_q, head_d;
  logic          coll_q, coll_d;

  logic          wr_en;
  logic [12:0]   cur_pos, seg_pos, head_pos;
  logic [7:0]    ex, ey, qx8, qy8;
  logic          q_hit, last_idx;
  logic [LW-1:0] gp_inc;
  logic          unused_ok;

  assign unused_ok = ^{xpos[8:7], ypos[8:6]};

  always_comb begin
    cur_pos  = {xpos[6:0], ypos[5:0]};
    seg_pos  = ring_q[wp_q - idx_q];
    head_pos = ring_q[wp_q];
    ex  = {1'b0, seg_pos[12:6]};
    ey  = {2'b0, seg_pos[5:0]};
    qx8 = {1'b0, qx_q};
    qy8 = {2'b0, qy_q};
    // 8-bit sums so a segment near the right/bottom edge never wraps
    q_hit = (qx8 >= ex) && (qx8 <= ex + 8'(BOX - 1)) &&
            (qy8 >= ey) && (qy8 <= ey + 8'(BOX - 1));
    last_idx = (LW'(idx_q) == length_q - LW'(1));
    gp_inc = (grow && (grow_pend_q < LW'(DEPTH) - length_q)) ?
             grow_pend_q + LW'(1) : grow_pend_q;

    wp_d        = wp_q;
    last_head_d = last_head_q;
    adv_pos_d   = adv_pos_q;
    adv_pend_d  = adv_pend_q;
    grow_pend_d = gp_inc;
    length_d    = length_q;
    state_d     = state_q;
    idx_d       = idx_q;
    qx_d        = qx_q;
    qy_d        = qy_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    head_d      = head_q;
    coll_d      = coll_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (adv_pend_q) begin
          wr_en      = 1'b1;
          wp_d       = wp_q + AW'(1);
          adv_pend_d = 1'b0;
          if (gp_inc != '0 && length_q < LW'(DEPTH)) begin
            length_d    = length_q + LW'(1);
            grow_pend_d = gp_inc - LW'(1);
          end
          if (length_d > LW'(1)) begin
            state_d = S_CSCAN;
            idx_d   = AW'(1);
          end
        end else if (query_valid) begin
          qx_d    = query_x;
          qy_d    = query_y;
          idx_d   = '0;
          state_d = S_QSCAN;
        end
      end
      S_QSCAN: begin
        if (q_hit) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          head_d  = (idx_q == '0);
          state_d = S_IDLE;
        end else if (last_idx) begin
          done_d  = 1'b1;
          hit_d   = 1'b0;
          head_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_CSCAN: begin
        if (head_pos == seg_pos) coll_d = 1'b1;
        if (last_idx) state_d = S_IDLE;
        else          idx_d   = idx_q + AW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh head change overrides any consume above; latest position wins
    if (cur_pos != last_head_q) begin
      last_head_d = cur_pos;
      adv_pos_d   = cur_pos;
      adv_pend_d  = 1'b1;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      wp_q        <= '0;
      last_head_q <= '0;
      adv_pos_q   <= '0;
      adv_pend_q  <= 1'b0;
      grow_pend_q <= '0;
      length_q    <= LW'(INIT_LEN);
      state_q     <= S_IDLE;
      idx_q       <= '0;
      qx_q        <= '0;
      qy_q        <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      head_q      <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      last_head_q <= last_head_d;
      adv_pos_q   <= adv_pos_d;
      adv_pend_q  <= adv_pend_d;
      grow_pend_q <= grow_pend_d;
      length_q    <= length_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      qx_q        <= qx_d;
      qy_q        <= qy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      head_q      <= head_d;
      coll_q      <= coll_d;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
    end else if (wr_en) begin
      ring_q[wp_d] <= adv_pos_q;
    end
  end

  assign query_ready    = (state_q == S_IDLE) && !adv_pend_q;
  assign query_done     = done_q;
  assign query_hit      = hit_q;
  assign query_head     = head_q;
  assign length         = length_q;
  assign self_collision = coll_q;
endmodule

// File: tb/tb_snake_trail.sv
// Directed self-checking bench for snake_trail: hit-test latency, growth,
// self-collision, advance-over-query priority and mid-scan reset.
module tb_snake_trail;
  logic       slow_clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] xpos = '0, ypos = '0;
  logic       grow = 1'b0, query_valid = 1'b0;
  logic [6:0] query_x = '0;
  logic [5:0] query_y = '0;
  logic       query_ready, query_done, query_hit, query_head, self_collision;
  logic [4:0] length;

  int n_chk = 0, n_fail = 0;

  snake_trail dut (
    .slow_clk(slow_clk), .reset(reset), .xpos(xpos), .ypos(ypos),
    .grow(grow), .query_valid(query_valid), .query_x(query_x),
    .query_y(query_y), .query_ready(query_ready), .query_done(query_done),
    .query_hit(query_hit), .query_head(query_head), .length(length),
    .self_collision(self_collision)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge slow_clk);
    #1;
  endtask

  // Present a new head, count cycles until query_ready returns
  task automatic move(input int x, input int y, input int exp_ticks, input int exp_len);
    int n;
    xpos = 9'(x);
    ypos = 9'(y);
    n = 0;
    do begin
      tick();
      n++;
    end while (!query_ready && n < 40);
    chk("adv_ticks", n, exp_ticks);
    chk("adv_length", {27'd0, length}, exp_len);
  endtask

  task automatic query(input int x, input int y, input int lat, input int eh, input int ehd);
    chk("q_ready", {31'd0, query_ready}, 1);
    query_valid = 1'b1;
    query_x = 7'(x);
    query_y = 6'(y);
    tick();
    query_valid = 1'b0;
    repeat (lat - 2) tick();
    chk("q_done_early", {31'd0, query_done}, 0);
    tick();
    chk("q_done", {31'd0, query_done}, 1);
    chk("q_hit", {31'd0, query_hit}, eh);
    chk("q_head", {31'd0, query_head}, ehd);
  endtask

  initial begin
    int n;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_length", {27'd0, length}, 3);
    chk("rst_ready", {31'd0, query_ready}, 1);
    chk("rst_coll", {31'd0, self_collision}, 0);
    chk("rst_done", {31'd0, query_done}, 0);

    // All entries at (0,0): head hit
    query(2, 2, 2, 1, 1);
    tick();
    chk("done_pulse", {31'd0, query_done}, 0);

    move(10, 10, 4, 3);
    query(14, 14, 2, 1, 1);
    tick();
    chk("hit_hold", {31'd0, query_hit}, 1);
    chk("head_hold", {31'd0, query_head}, 1);
    query(15, 10, 4, 0, 0);

    // Growth: two pending grows consumed by the next two advances
    grow = 1'b1; tick(); grow = 1'b0; tick();
    grow = 1'b1; tick(); grow = 1'b0; tick();
    chk("grow_len_pending", {27'd0, length}, 3);
    move(30, 10, 5, 4);
    move(40, 10, 6, 5);
    move(50, 10, 6, 5);

    move(0, 0, 6, 5);
    move(10, 0, 6, 5);
    move(20, 0, 6, 5);
    chk("coll_before", {31'd0, self_collision}, 0);
    move(10, 0, 6, 5);
    chk("coll_set", {31'd0, self_collision}, 1);
    move(60, 0, 6, 5);
    chk("coll_sticky", {31'd0, self_collision}, 1);

    // Query raised while an advance is pending waits for advance + scan
    xpos = 9'd70; ypos = 9'd20;
    tick();
    chk("pend_ready", {31'd0, query_ready}, 0);
    query_valid = 1'b1; query_x = 7'd72; query_y = 6'd22;
    n = 0;
    do begin
      tick();
      n++;
    end while (!query_ready && n < 40);
    chk("stall_ticks", n, 5);
    tick();
    query_valid = 1'b0;
    tick();
    chk("stall_done", {31'd0, query_done}, 1);
    chk("stall_hit", {31'd0, query_hit}, 1);
    chk("stall_head", {31'd0, query_head}, 1);

    // Box edge boundaries and a non-head hit
    query(74, 24, 2, 1, 1);
    query(75, 24, 6, 0, 0);
    query(62, 2, 3, 1, 0);

    // Reset in the middle of a query scan
    query_valid = 1'b1; query_x = 7'd120; query_y = 6'd50;
    tick();
    query_valid = 1'b0;
    tick();
    reset = 1'b1; xpos = '0; ypos = '0;
    tick();
    reset = 1'b0;
    chk("mid_rst_done", {31'd0, query_done}, 0);
    chk("mid_rst_ready", {31'd0, query_ready}, 1);
    chk("mid_rst_length", {27'd0, length}, 3);
    chk("mid_rst_coll", {31'd0, self_collision}, 0);
    chk("mid_rst_hit", {31'd0, query_hit}, 0);
    tick();
    chk("mid_rst_done2", {31'd0, query_done}, 0);
    chk("mid_rst_ready2", {31'd0, query_ready}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_trail.md
# snake_trail

Ring buffer of recent snake head positions, sitting directly downstream of the physics stage that produces the 5x5 box's top-left `xpos`/`ypos` on `slow_clk`. Every time the head moves, the block records the new position and keeps the last `length` positions as the snake body. It answers serial pixel hit-test queries against that body for the OLED renderer, and flags self-collision when the head lands exactly on an older segment.

## Interface
- `DEPTH`, 16: ring entries (power of two); maximum body length.
- `BOX`, 5: segment edge in pixels.
- `INIT_LEN`, 3: body length after reset (1..DEPTH).
- `slow_clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `xpos` in 9: head top-left x from physics stage (0..91); bits [6:0] used.
- `ypos` in 9: head top-left y (0..59); bits [5:0] used.
- `grow` in 1: one-cycle request to lengthen body by one segment.
- `query_valid` in 1: pixel query request.
- `query_x` in 7, `query_y` in 6: pixel under test.
- `query_ready` out 1: high when a query is accepted this cycle.
- `query_done` out 1: one-cycle pulse, result valid.
- `query_hit` out 1: pixel lies inside some segment (valid with `query_done`).
- `query_head` out 1: hit segment is index 0, the head (valid with `query_done`).
- `length` out 5: current body length.
- `self_collision` out 1: sticky collision flag.

## Operation
- Storage: `DEPTH` entries of {x[6:0], y[5:0]}, plus write pointer `wp`. Segment i (0 = head) is `buf[(wp - i) mod DEPTH]`.
- Reset: all entries = (0,0), `wp`=0, `last_head`=(0,0), `length`=`INIT_LEN`, `grow_pend`=0, `adv_pend`=0, state IDLE. All outputs 0 except `length` and `query_ready`=1.
- Head change detect, every cycle: if {xpos[6:0], ypos[5:0]} != `last_head`, set `last_head` to the new value, set `adv_pend`=1 and latch the value as `adv_pos`. A later change while pending overwrites `adv_pos`; only the latest position is kept.
- Grow: a `grow` pulse increments `grow_pend`, saturating at `DEPTH - length`.
- States: IDLE, QSCAN, CSCAN.
- IDLE, `adv_pend`=1 (has priority over queries):
  - `wp`++ and write `adv_pos` at the new `wp`.
  - Clear `adv_pend`.
  - If `grow_pend`>0 and `length`<DEPTH: `length`++ and `grow_pend`--.
  - If the resulting `length`>1, go to CSCAN with i=1. Otherwise stay in IDLE.
- IDLE, `query_valid`=1 and `adv_pend`=0: latch the query, i=0, go to QSCAN.
- QSCAN: each cycle examine segment i.
  - Hit when ex <= qx <= ex+BOX-1 and ey <= qy <= ey+BOX-1. Sums are computed 8 bits wide, with no wrap.
  - On hit: next cycle `query_done`=1, `query_hit`=1, `query_head`=(i==0), return to IDLE.
  - If i==`length`-1 with no hit: next cycle `query_done`=1 with `query_hit`=0, return to IDLE.
- CSCAN: each cycle compare segment 0 with segment i for exact top-left equality. On equality set `self_collision`=1. After i==`length`-1, return to IDLE. No early exit.
- `self_collision` clears only on reset.
- Reset mid-scan: abort to IDLE with no `query_done` pulse.

## Timing
- `query_ready` = (state==IDLE) && !`adv_pend`, combinational from registers.
- A query accepted at cycle T examines segment i in cycle T+1+i.
  - Hit at i: `query_done` in cycle T+2+i.
  - Miss: `query_done` in cycle T+1+`length`.
- `query_hit`/`query_head` hold until the next `query_done`. `query_done` is 1 cycle wide.
- Advance: change seen at cycle C → `adv_pend` visible at C+1 → write in the first IDLE cycle A ≥ C+1.
  - `length` updates at A+1.
  - CSCAN occupies A+1 .. A+`length`-1, using the new `length`.
  - `self_collision` rises the cycle after the matching compare.
- Simultaneous `grow` and advance in the same cycle: the pending count includes the new grow before it is consumed.
- Worst-case query stall is `DEPTH` cycles.

## Test plan
- Reset, then hold inputs constant: `length`=3, `query_ready`=1, `self_collision`=0. Query (2,2) → `query_done` at T+2, `query_hit`=1, `query_head`=1 (all entries at (0,0)).
- Step head to (10,10). Query (14,14) → hit at T+2 with `query_head`=1. Query (15,10) → miss, `query_done` at T+4.
- Pulse `grow` twice, then make 3 head moves → `length` goes 3→4→5→5.
- Move head (0,0)→(10,0)→(20,0)→(10,0) with `length`≥3 → `self_collision`=1 during the CSCAN after the last move, and it stays 1.
- Assert `query_valid` in the same cycle a head change occurs → advance and CSCAN run first. Query is accepted when `query_ready` returns to 1, and the result reflects the new head.
- Assert `reset` during QSCAN → no `query_done`, next cycle state IDLE, `length`=3.
